decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL have parameter SEL_W, default 5, select width in bits, legal range 1..8.
REQ-002 SHALL have parameter DWELL, default 4, clock cycles each scan step is held, legal range >=1.
REQ-003 SHALL derive local constant OUT_W = 2**SEL_W, the output width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port enable  input  1  output enable; low forces out to zero.
REQ-008 SHALL have port mode  input  1  0 = direct decode, 1 = scan.
REQ-009 SHALL have port select  input  SEL_W  direct-mode index.
REQ-010 SHALL have port start  input  1  single-cycle request to begin a scan sweep.
REQ-011 SHALL have port cont  input  1  1 = wrap continuously, 0 = single sweep.
REQ-012 SHALL have port out  output  OUT_W  registered one-hot (or all-zero) select lines.
REQ-013 SHALL have port index  output  SEL_W  currently decoded index.
REQ-014 SHALL have port busy  output  1  high while in SCAN state.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a single sweep completes.

Function
REQ-016 SHALL implement states IDLE, DIRECT and SCAN.
REQ-017 SHALL be in IDLE when mode=0: next-cycle out = enable ? onehot(select) : 0; index = select registered; latency 1 cycle.
REQ-018 SHALL be in IDLE when mode=1 and no scan is active: out = 0; index = 0.
REQ-019 SHALL treat DIRECT as IDLE with mode=0; only SCAN holds sweep state.
REQ-020 SHALL, on start=1 with mode=1 and not busy, enter SCAN with index=0 and dwell counter=0; out=onehot(0) on the following edge when enable=1.
REQ-021 SHALL increment the dwell counter each enabled SCAN cycle; at count DWELL-1 it clears the counter and advances index by 1.
REQ-022 SHALL wrap at index OUT_W-1 dwell end: with cont=1, index returns to 0 and busy stays high; with cont=0, it returns to IDLE, drives done=1 for exactly one cycle, and clears out and busy on that same edge.
REQ-023 SHALL, on enable=0 during SCAN, pause: hold index and dwell counter, force out=0, keep busy=1; resume unchanged on enable=1.
REQ-024 SHALL ignore start while busy, or while mode=0.
REQ-025 SHALL, on mode 1->0 during SCAN, abort to IDLE next edge: no done pulse; direct-mode decoding starts on that edge.
REQ-026 SHALL let cont be sampled at the wrap point only, so a mid-sweep change takes effect at the next wrap.
REQ-027 SHALL keep out one-hot or all-zero in every cycle; never more than one bit set.
REQ-028 SHALL make DWELL=1 advance index every enabled cycle.

Reset
REQ-029 SHALL, on reset_n=0, asynchronously set state=IDLE, out=0, index=0, busy=0, done=0 and dwell counter=0.
REQ-030 SHALL produce no done pulse when reset is asserted mid-scan; first valid output appears one edge after reset_n deasserts.

Structure
REQ-031 SHALL place the state encoding (IDLE, DIRECT, SCAN) and mode constants (MODE_DIRECT=0, MODE_SCAN=1) in shared package decoder_pkg.
REQ-032 SHALL instantiate one combinational sub-module, decoder_onehot (parameter SEL_W; ports enable, select, out), for both modes.
REQ-033 SHALL size the dwell counter $clog2(DWELL) bits, minimum 1 bit.

Verification
REQ-034 SHALL cover: SEL_W=5, mode=0, enable=1, select swept 0..31 -> out=1<<select one cycle later; enable=0 -> out=0.
REQ-035 SHALL cover: mode=1, DWELL=4, cont=0, start pulse -> each index 0..31 held 4 cycles, done high one cycle after index 31, busy low thereafter.
REQ-036 SHALL cover: cont=1 -> index 31 followed by index 0 with no done; clearing cont mid-sweep -> done at end of that sweep.
REQ-037 SHALL cover: enable low for 10 cycles at index 7 -> out=0 throughout; resume at index 7 with remaining dwell intact.
REQ-038 SHALL cover: start repeated while busy -> no restart; mode->0 at index 12 -> no done, direct decode next edge.
REQ-039 SHALL cover: reset_n low mid-scan asynchronously -> all outputs 0 immediately; SEL_W=3, DWELL=1 sweep -> 8 steps, done after step 7.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared constants for the decoder_scan block: controller state encoding and mode values.
package decoder_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_onehot.sv
// Combinational index-to-one-hot decoder; all-zero output when not enabled.
module decoder_onehot #(
  parameter int SEL_W = 5
) (
  input  logic                    enable,
  input  logic [SEL_W-1:0]        select,
  output logic [(2**SEL_W)-1:0]   out
);

  always_comb begin
    out = '0;
    if (enable) out[select] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan.sv
// Select-line driver: direct one-hot decode of an index, or a timed scan sweep over all lines.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | mode=1, no sweep active; out and index held at zero
// ST_DIRECT | mode=0; out/index follow select one cycle later
// ST_SCAN   | sweep active; index advances every DWELL enabled cycles
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W = 5,
  parameter int DWELL = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      select,
  input  logic                  start,
  input  logic                  cont,
  output logic [(2**SEL_W)-1:0] out,
  output logic [SEL_W-1:0]      index,
  output logic                  busy,
  output logic                  done
);

  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = '1;

  logic [1:0]       state, state_n;
  logic [SEL_W-1:0] idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             done_n;
  logic             dec_en;
  logic [SEL_W-1:0] dec_sel;
  logic [OUT_W-1:0] dec_out;

  decoder_onehot #(.SEL_W(SEL_W)) u_onehot (
    .enable (dec_en),
    .select (dec_sel),
    .out    (dec_out)
  );

  always_comb begin
    state_n = state;
    idx_n   = index;
    cnt_n   = cnt;
    done_n  = 1'b0;
    dec_en  = 1'b0;
    dec_sel = index;
    if (state == ST_SCAN && mode == MODE_SCAN) begin
      // a disabled cycle is a pause: counters hold and lines stay dark
      if (enable) begin
        dec_en = 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (index == IDX_LAST) begin
            idx_n = '0;
            if (!cont) begin
              state_n = ST_IDLE;
              done_n  = 1'b1;
              dec_en  = 1'b0;
            end
          end else begin
            idx_n = index + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
        dec_sel = idx_n;
      end
    end else if (mode == MODE_DIRECT) begin
      state_n = ST_DIRECT;
      idx_n   = select;
      cnt_n   = '0;
      dec_en  = enable;
      dec_sel = select;
    end else if (start) begin
      state_n = ST_SCAN;
      idx_n   = '0;
      cnt_n   = '0;
      dec_en  = enable;
      dec_sel = '0;
    end else begin
      state_n = ST_IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      index <= '0;
      cnt   <= '0;
      out   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      index <= idx_n;
      cnt   <= cnt_n;
      out   <= dec_out;
      done  <= done_n;
    end
  end

  assign busy = (state == ST_SCAN);

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: two instances (SEL_W=5/DWELL=4 and SEL_W=3/DWELL=1) on shared stimulus,
// compared every cycle against a sweep-position reference model.
module tb_decoder_scan;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable, mode, start, cont;
  logic [4:0] select;

  logic [31:0] out5;
  logic [4:0]  idx5;
  logic        busy5, done5;
  logic [7:0]  out3;
  logic [2:0]  idx3;
  logic        busy3, done3;

  int tests = 0;
  int fails = 0;
  int n, d5, d3;

  always #5 clock = ~clock;

  decoder_scan #(.SEL_W(5), .DWELL(4)) dut5 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
    .select(select), .start(start), .cont(cont),
    .out(out5), .index(idx5), .busy(busy5), .done(done5)
  );

  decoder_scan #(.SEL_W(3), .DWELL(1)) dut3 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
    .select(select[2:0]), .start(start), .cont(cont),
    .out(out3), .index(idx3), .busy(busy3), .done(done3)
  );

  // Model: a sweep is a count of enabled cycles, pos; the shown line is pos / dwell.
  typedef struct {
    bit           scan;
    int           pos;
    int           idx;
    bit           done;
    logic [255:0] out;
  } m_t;

  m_t m5, m3;

  function automatic m_t m_reset();
    m_t r;
    r.scan = 0; r.pos = 0; r.idx = 0; r.done = 0; r.out = '0;
    return r;
  endfunction

  function automatic m_t step(m_t s, int sw, int dw, bit en, bit md, int sel, bit st, bit ct);
    m_t r = s;
    int len = (1 << sw) * dw;
    r.done = 0;
    if (s.scan && md) begin
      if (en) begin
        r.pos = s.pos + 1;
        if (r.pos == len) begin
          r.pos = 0;
          if (!ct) begin
            r.scan = 0;
            r.done = 1;
          end
        end
      end
      r.idx = r.scan ? r.pos / dw : 0;
      r.out = (r.scan && en) ? (256'b1 << r.idx) : '0;
    end else if (!md) begin
      r.scan = 0;
      r.idx  = sel;
      r.out  = en ? (256'b1 << sel) : '0;
    end else if (st) begin
      r.scan = 1;
      r.pos  = 0;
      r.idx  = 0;
      r.out  = en ? 256'b1 : '0;
    end else begin
      r.idx = 0;
      r.out = '0;
    end
    return r;
  endfunction

  task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    check("out5",  256'(out5),  m5.out);
    check("idx5",  256'(idx5),  256'(m5.idx));
    check("busy5", 256'(busy5), 256'(m5.scan));
    check("done5", 256'(done5), 256'(m5.done));
    check("out3",  256'(out3),  m3.out);
    check("idx3",  256'(idx3),  256'(m3.idx));
    check("busy3", 256'(busy3), 256'(m3.scan));
    check("done3", 256'(done3), 256'(m3.done));
  endtask

  task automatic cyc();
    @(posedge clock);
    m5 = step(m5, 5, 4, enable, mode, int'(select), start, cont);
    m3 = step(m3, 3, 1, enable, mode, int'(select[2:0]), start, cont);
    #1;
    chk_all();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0; mode = 1'b0; start = 1'b0; cont = 1'b0; select = '0;
    m5 = m_reset();
    m3 = m_reset();
    #2;
    chk_all();
    @(negedge clock);
    reset_n = 1'b1;

    // direct decode sweep, then enable low
    enable = 1'b1;
    for (int s = 0; s < 32; s++) begin
      select = 5'(s);
      cyc();
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      select = 5'($urandom);
      cyc();
    end

    // single sweep: done lands after 32*4 edges (big) and 8*1 edges (small)
    enable = 1'b1; mode = 1'b1; cont = 1'b0;
    cyc();
    pulse_start();
    d5 = 0; d3 = 0;
    for (int i = 1; i <= 140; i++) begin
      cyc();
      if (done5 && d5 == 0) d5 = i;
      if (done3 && d3 == 0) d3 = i;
    end
    check("sweep5_len", 256'(d5), 256'(128));
    check("sweep3_len", 256'(d3), 256'(8));

    // continuous wrap, then clear cont mid-sweep
    cont = 1'b1;
    pulse_start();
    n = 0;
    while (idx5 != 5'd31 && n < 200) begin cyc(); n++; end
    check("wait_idx31", 256'(idx5), 256'(31));
    n = 0;
    while (idx5 != 5'd0 && n < 20) begin cyc(); n++; end
    check("wrap_idx0", 256'(idx5), 256'(0));
    check("wrap_busy", 256'(busy5), 256'(1));
    n = 0;
    while (idx5 != 5'd5 && n < 40) begin cyc(); n++; end
    cont = 1'b0;
    n = 0;
    while (!done5 && n < 200) begin cyc(); n++; end
    check("cont_clear_done", 256'(done5), 256'(1));
    cyc();

    // pause at index 7 with two dwell cycles already spent
    pulse_start();
    n = 0;
    while (idx5 != 5'd7 && n < 60) begin cyc(); n++; end
    cyc();
    cyc();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    enable = 1'b1;
    n = 0;
    while (idx5 != 5'd8 && n < 20) begin cyc(); n++; end
    check("resume_dwell", 256'(n), 256'(2));

    // start while busy is ignored; mode drop aborts without done
    for (int i = 0; i < 3; i++) begin
      pulse_start();
      cyc();
    end
    n = 0;
    while (idx5 != 5'd12 && n < 40) begin cyc(); n++; end
    mode = 1'b0;
    select = 5'd9;
    cyc();
    check("abort_out", 256'(out5), 256'(32'h200));
    check("abort_done", 256'(done5), 256'(0));
    mode = 1'b1;
    cyc();

    // async reset mid-scan
    pulse_start();
    for (int i = 0; i < 20; i++) cyc();
    #2;
    reset_n = 1'b0;
    #1;
    m5 = m_reset();
    m3 = m_reset();
    chk_all();
    @(negedge clock);
    reset_n = 1'b1;
    cyc();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      mode   = ($urandom_range(7) != 0);
      enable = ($urandom_range(5) != 0);
      start  = ($urandom_range(9) == 0);
      cont   = $urandom_range(1) == 1;
      select = 5'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
